// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer for the MSP430 CPU.
//
// Each decoded instruction is broken into the bus cycles its addressing modes
// need. They are issued in a fixed order: source extension word, source read,
// destination extension word, destination read, execute, destination
// write-back. A stage whose condition is false costs no cycles, so the choice
// of next state is made combinationally. When the constant generator supplies
// an operand, that operand gets no memory cycles.
//
// Ports:
//   MCLK, RST_n          clock, asynchronous active-low reset
//   start                decoded instruction valid (sampled only in IDLE)
//   Format, isJump       instruction class
//   srcA, As, dstA, Ad   register fields and addressing modes
//   BW                   byte operation (selects the autoincrement size)
//   srcGenerated,
//   dstGenerated         constant generator supplied source / destination
//   noDstRead            destination is not read before execute
//   noWriteBack          result is not written back
//   mem_ack              bus completion for the current request
//   mem_req, mem_op      bus request and cycle type (held until ack)
//   incPC                PC += 2 pulse on an extension word ack
//   incSrc, incAmt       autoincrement pulse and its size
//   exec                 one-cycle ALU execute strobe
//   busy                 high in every state except IDLE
//   done, fault          one-cycle completion / bus timeout pulses
module operand_fetch_sequencer #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic       MCLK,
    input  logic       RST_n,
    input  logic       start,
    input  logic       Format,
    input  logic       isJump,
    input  logic [3:0] srcA,
    input  logic [1:0] As,
    input  logic [3:0] dstA,
    input  logic       Ad,
    input  logic       BW,
    input  logic       srcGenerated,
    input  logic       dstGenerated,
    input  logic       noDstRead,
    input  logic       noWriteBack,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic [1:0] mem_op,
    output logic       incPC,
    output logic       incSrc,
    output logic [1:0] incAmt,
    output logic       exec,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    // The encodings of the memory states are 1..4, in issue order. They line
    // up with bits 0..3 of the need vector below.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SRC_EXT = 3'd1,
        SRC_RD  = 3'd2,
        DST_EXT = 3'd3,
        DST_RD  = 3'd4,
        EXEC    = 3'd5,
        WB      = 3'd6
    } stateT;

    typedef enum logic [1:0] {
        OP_FETCH_EXT = 2'd0,
        OP_READ_SRC  = 2'd1,
        OP_READ_DST  = 2'd2,
        OP_WRITE_DST = 2'd3
    } memOpT;

    stateT             state, stateNext;
    logic [WAIT_W-1:0] waitCnt;

    // need[0]=SRC_EXT, need[1]=SRC_RD, need[2]=DST_EXT, need[3]=DST_RD
    logic [3:0] decNeed, needQ;
    logic       decWb, wbQ;
    logic       decAutoSrc, autoSrcQ;
    logic       decAutoDst, autoDstQ;
    logic [1:0] decAmt, amtQ;
    logic [3:0] modeReg;
    logic       modeImm;

    logic       memState;
    logic       timeout;
    logic       doneQ, faultQ;
    memOpT      opSel;

    // Returns the first needed memory stage at or after stage index 'from'.
    // Returns EXEC if no later stage is needed.
    function automatic stateT firstFrom(input logic [3:0] need, input int unsigned from);
        stateT s;
        logic  found;
        s     = EXEC;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && i >= from && need[i]) begin
                s     = stateT'(3'(i + 1));
                found = 1'b1;
            end
        end
        return s;
    endfunction

    // Decode the live instruction fields. The results are latched on start.
    always_comb begin
        decNeed    = '0;
        decWb      = 1'b0;
        decAutoSrc = 1'b0;
        decAutoDst = 1'b0;
        modeReg    = Format ? dstA : srcA;
        modeImm    = (As == 2'b11) && (modeReg == 4'd0);
        decAmt     = (!BW || modeReg == 4'd1) ? 2'd2 : 2'd1;
        if (!isJump) begin
            if (!Format) begin
                if (!srcGenerated) begin
                    case (As)
                        2'b01:   decNeed[1:0] = 2'b11;
                        2'b10:   decNeed[1]   = 1'b1;
                        2'b11: begin
                            if (modeImm) begin
                                decNeed[0] = 1'b1;
                            end else begin
                                decNeed[1] = 1'b1;
                                decAutoSrc = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (Ad && !dstGenerated) begin
                    decNeed[2] = 1'b1;
                    decNeed[3] = !noDstRead;
                    decWb      = !noWriteBack;
                end
            end else if (!dstGenerated) begin
                case (As)
                    2'b01:   decNeed[3:2] = 2'b11;
                    2'b10:   decNeed[3]   = 1'b1;
                    2'b11: begin
                        if (modeImm) begin
                            decNeed[2] = 1'b1;
                        end else begin
                            decNeed[3] = 1'b1;
                            decAutoDst = 1'b1;
                        end
                    end
                    default: ;
                endcase
                decWb = (As != 2'b00) && !noWriteBack && !modeImm;
            end
        end
    end

    always_comb begin
        stateNext = state;
        memState  = 1'b0;
        opSel     = OP_FETCH_EXT;
        incPC     = 1'b0;
        incSrc    = 1'b0;
        exec      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (start) stateNext = firstFrom(decNeed, 0);
            end
            SRC_EXT: begin
                memState = 1'b1;
                opSel    = OP_FETCH_EXT;
                if (mem_ack) begin
                    incPC     = 1'b1;
                    stateNext = firstFrom(needQ, 1);
                end
            end
            SRC_RD: begin
                memState = 1'b1;
                opSel    = OP_READ_SRC;
                if (mem_ack) begin
                    incSrc    = autoSrcQ;
                    stateNext = firstFrom(needQ, 2);
                end
            end
            DST_EXT: begin
                memState = 1'b1;
                opSel    = OP_FETCH_EXT;
                if (mem_ack) begin
                    incPC     = 1'b1;
                    stateNext = firstFrom(needQ, 3);
                end
            end
            DST_RD: begin
                memState = 1'b1;
                opSel    = OP_READ_DST;
                if (mem_ack) begin
                    incSrc    = autoDstQ;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                exec      = 1'b1;
                stateNext = wbQ ? WB : IDLE;
            end
            WB: begin
                memState = 1'b1;
                opSel    = OP_WRITE_DST;
                if (mem_ack) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // The last unacknowledged cycle of the wait budget aborts the request.
        if (memState && !mem_ack && waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
            timeout   = 1'b1;
            stateNext = IDLE;
        end
    end

    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            waitCnt  <= '0;
            needQ    <= '0;
            wbQ      <= 1'b0;
            autoSrcQ <= 1'b0;
            autoDstQ <= 1'b0;
            amtQ     <= '0;
            doneQ    <= 1'b0;
            faultQ   <= 1'b0;
        end else begin
            state <= stateNext;
            if (stateNext != state) begin
                waitCnt <= '0;
            end else if (memState && !mem_ack) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (state == IDLE && start) begin
                needQ    <= decNeed;
                wbQ      <= decWb;
                autoSrcQ <= decAutoSrc;
                autoDstQ <= decAutoDst;
                amtQ     <= decAmt;
            end
            doneQ  <= (stateNext == IDLE) && (state == EXEC || state == WB) && !timeout;
            faultQ <= timeout;
        end
    end

    // mem_req is decoded from state, so an asynchronous reset drops it at once.
    assign mem_req = memState;
    assign mem_op  = memState ? opSel : OP_FETCH_EXT;
    assign incAmt  = incSrc ? amtQ : 2'd0;
    assign busy    = (state != IDLE);
    assign done    = doneQ;
    assign fault   = faultQ;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
module tb_operand_fetch_sequencer;

    logic       MCLK;
    logic       RST_n;
    logic       start;
    logic       Format;
    logic       isJump;
    logic [3:0] srcA;
    logic [1:0] As;
    logic [3:0] dstA;
    logic       Ad;
    logic       BW;
    logic       srcGenerated;
    logic       dstGenerated;
    logic       noDstRead;
    logic       noWriteBack;
    logic       mem_ack;
    logic       mem_req;
    logic [1:0] mem_op;
    logic       incPC;
    logic       incSrc;
    logic [1:0] incAmt;
    logic       exec;
    logic       busy;
    logic       done;
    logic       fault;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Observation word: {mem_req, mem_op, incPC, incSrc, incAmt, exec, busy, done, fault}
    logic [10:0] obsW;
    assign obsW = {mem_req, mem_op, incPC, incSrc, incAmt, exec, busy, done, fault};

    localparam logic [10:0] IDLE0   = 11'b0_00_0_0_00_0_0_0_0;
    localparam logic [10:0] DONE    = 11'b0_00_0_0_00_0_0_1_0;
    localparam logic [10:0] FAULT   = 11'b0_00_0_0_00_0_0_0_1;
    localparam logic [10:0] EXECO   = 11'b0_00_0_0_00_1_1_0_0;
    localparam logic [10:0] EXT_ACK = 11'b1_00_1_0_00_0_1_0_0;
    localparam logic [10:0] RS      = 11'b1_01_0_0_00_0_1_0_0;
    localparam logic [10:0] RS_INC1 = 11'b1_01_0_1_01_0_1_0_0;
    localparam logic [10:0] RD      = 11'b1_10_0_0_00_0_1_0_0;
    localparam logic [10:0] RD_INC2 = 11'b1_10_0_1_10_0_1_0_0;
    localparam logic [10:0] WR      = 11'b1_11_0_0_00_0_1_0_0;

    operand_fetch_sequencer #(.MAX_WAIT(8), .WAIT_W(4)) dut (
        .MCLK(MCLK), .RST_n(RST_n), .start(start), .Format(Format), .isJump(isJump),
        .srcA(srcA), .As(As), .dstA(dstA), .Ad(Ad), .BW(BW),
        .srcGenerated(srcGenerated), .dstGenerated(dstGenerated),
        .noDstRead(noDstRead), .noWriteBack(noWriteBack), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_op(mem_op), .incPC(incPC), .incSrc(incSrc),
        .incAmt(incAmt), .exec(exec), .busy(busy), .done(done), .fault(fault)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic cycle(input logic st, input logic ack);
        @(negedge MCLK);
        start   = st;
        mem_ack = ack;
        #1;
    endtask

    task automatic setInstr(input logic fmt, input logic jmp, input logic [3:0] sA,
                            input logic [1:0] as_, input logic [3:0] dA, input logic ad_,
                            input logic bw, input logic sg, input logic dg,
                            input logic ndr, input logic nwb);
        Format = fmt; isJump = jmp; srcA = sA; As = as_; dstA = dA; Ad = ad_;
        BW = bw; srcGenerated = sg; dstGenerated = dg; noDstRead = ndr; noWriteBack = nwb;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obsW !== IDLE0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obsW, IDLE0);
        end
        @(negedge MCLK);
        RST_n = 1'b1;
        #1;
        checks++;
        if (obsW !== IDLE0) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obsW, IDLE0);
        end
    endtask

    // MOV #0x1234,R5
    task automatic test_mov_imm();
        logic [10:0] ev [5];
        logic [4:0]  ackv, stv;
        setInstr(1'b0, 1'b0, 4'd0, 2'b11, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ev   = '{IDLE0, EXT_ACK, EXECO, DONE, IDLE0};
        ackv = 5'b00010;
        stv  = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL mov_imm cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // ADD.B @R6+,&0x0200 with a source wait state, an ack during EXEC and a WB wait state
    task automatic test_add_autoinc_abs();
        logic [10:0] ev [10];
        logic [9:0]  ackv, stv;
        setInstr(1'b0, 1'b0, 4'd6, 2'b11, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ev   = '{IDLE0, RS, RS_INC1, EXT_ACK, RD, EXECO, WR, WR, DONE, IDLE0};
        ackv = 10'b0010111100;
        stv  = 10'b0000000001;
        for (int i = 0; i < 10; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL add_autoinc_abs cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // ADD #8,R4: constant generator source, an ack while idle is ignored
    task automatic test_const_gen();
        logic [10:0] ev [4];
        logic [3:0]  ackv, stv;
        setInstr(1'b0, 1'b0, 4'd2, 2'b11, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ev   = '{IDLE0, EXECO, DONE, IDLE0};
        ackv = 4'b1000;
        stv  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL const_gen cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // PUSH 2(R7), with start held high while busy (must not queue)
    task automatic test_push_indexed();
        logic [10:0] ev [6];
        logic [5:0]  ackv, stv;
        setInstr(1'b1, 1'b0, 4'd0, 2'b01, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ev   = '{IDLE0, EXT_ACK, RD, EXECO, DONE, IDLE0};
        ackv = 6'b000110;
        stv  = 6'b001111;
        for (int i = 0; i < 6; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL push_indexed cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // Single-operand byte op on @SP+: increment stays 2, result written back
    task automatic test_fmt1_sp_autoinc();
        logic [10:0] ev [6];
        logic [5:0]  ackv, stv;
        setInstr(1'b1, 1'b0, 4'd0, 2'b11, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ev   = '{IDLE0, RD_INC2, EXECO, WR, DONE, IDLE0};
        ackv = 6'b001010;
        stv  = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL fmt1_sp_autoinc cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // Single-operand immediate: extension word is the operand, no write-back
    task automatic test_fmt1_imm();
        logic [10:0] ev [5];
        logic [4:0]  ackv, stv;
        setInstr(1'b1, 1'b0, 4'd0, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev   = '{IDLE0, EXT_ACK, EXECO, DONE, IDLE0};
        ackv = 5'b00010;
        stv  = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL fmt1_imm cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // MOV &abs,&abs: absolute source (R2, As=01), destination not read
    task automatic test_absolute_mov();
        logic [10:0] ev [8];
        logic [7:0]  ackv, stv;
        setInstr(1'b0, 1'b0, 4'd2, 2'b01, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ev   = '{IDLE0, EXT_ACK, RS, EXT_ACK, EXECO, WR, DONE, IDLE0};
        ackv = 8'b00101110;
        stv  = 8'b00000001;
        for (int i = 0; i < 8; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL absolute_mov cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // Jump: operand fields would otherwise need memory cycles
    task automatic test_jump();
        logic [10:0] ev [4];
        logic [3:0]  ackv, stv;
        setInstr(1'b0, 1'b1, 4'd5, 2'b01, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev   = '{IDLE0, EXECO, DONE, IDLE0};
        ackv = 4'b0000;
        stv  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL jump cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // Source read never acknowledged: 8 request cycles, then fault in IDLE
    task automatic test_timeout();
        logic [10:0] ev [11];
        logic [10:0] stv;
        setInstr(1'b0, 1'b0, 4'd5, 2'b10, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev  = '{IDLE0, RS, RS, RS, RS, RS, RS, RS, RS, FAULT, IDLE0};
        stv = 11'b00000000001;
        for (int i = 0; i < 11; i++) begin
            cycle(stv[i], 1'b0);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
    endtask

    // Reset asserted between clock edges while DST_RD is requesting
    task automatic test_reset_mid_op();
        logic [10:0] ev [3];
        logic [2:0]  ackv, stv;
        setInstr(1'b0, 1'b0, 4'd5, 2'b00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ev   = '{IDLE0, EXT_ACK, RD};
        ackv = 3'b010;
        stv  = 3'b001;
        for (int i = 0; i < 3; i++) begin
            cycle(stv[i], ackv[i]);
            checks++;
            if (obsW !== ev[i]) begin
                errors++;
                $display("FAIL reset_mid_op cycle %0d: got %b expected %b", i, obsW, ev[i]);
            end
        end
        #1;
        RST_n = 1'b0;
        #1;
        checks++;
        if (obsW !== IDLE0) begin
            errors++;
            $display("FAIL reset_async_drop: got %b expected %b", obsW, IDLE0);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (obsW !== IDLE0) begin
            errors++;
            $display("FAIL reset_no_pulse: got %b expected %b", obsW, IDLE0);
        end
        RST_n = 1'b1;
    endtask

    initial begin
        RST_n = 1'b0;
        start = 1'b0;
        mem_ack = 1'b0;
        setInstr(1'b0, 1'b0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_mov_imm();
        test_add_autoinc_abs();
        test_const_gen();
        test_push_indexed();
        test_fmt1_sp_autoinc();
        test_fmt1_imm();
        test_absolute_mov();
        test_jump();
        test_timeout();
        test_jump();
        test_reset_mid_op();
        test_mov_imm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
